// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage and decoder
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_INCR       = 2'd0,
        PC_IMM_OFFSET = 2'd1,
        PC_ALU_OUT    = 2'd2
    } pc_sel_e;

    typedef logic [31:0] data_val_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// rtl/fetch_unit_pc_next.sv - combinational next-PC selection and misalignment detect
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  pc_sel_e     pc_sel,
    input  data_val_t   imm_val,
    input  data_val_t   alu_out,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_sel)
            PC_INCR:       next_pc = pc + 32'd4;
            PC_IMM_OFFSET: next_pc = pc + imm_val;
            // JALR target: bit 0 is always cleared, bit 1 is left for the misalign check
            PC_ALU_OUT:    next_pc = {alu_out[31:1], 1'b0};
            default:       next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, retired counter, halt
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  pc_sel_e              i_pc_sel,
    input  data_val_t            i_imm_val,
    input  data_val_t            i_alu_out,
    input  logic                 i_exec_done,
    output logic                 o_imem_req,
    output logic [31:0]          o_imem_addr,
    input  logic                 i_imem_ack,
    input  instr_t               i_imem_rdata,
    output instr_t               o_cur_instr_val,
    output logic                 o_instr_vld,
    output logic [31:0]          o_pc_val,
    output logic [31:0]          o_pc_plus4,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_retired_cnt
);

    fetch_state_e         state;
    fetch_state_e         state_next;
    logic [31:0]          pc;
    logic [31:0]          next_pc;
    logic                 next_misaligned;
    logic                 commit;
    logic                 capture;
    instr_t               instr_q;
    logic                 vld_q;
    logic                 halted_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    fetch_unit_pc_next u_pc_next (
        .pc         (pc),
        .pc_sel     (i_pc_sel),
        .imm_val    (i_imm_val),
        .alu_out    (i_alu_out),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_imem_req = 1'b0;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    capture    = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                if (i_exec_done) begin
                    commit     = 1'b1;
                    state_next = next_misaligned ? HALT : FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc       <= RESET_PC;
            instr_q  <= '0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (capture) begin
                instr_q <= i_imem_rdata;
                vld_q   <= 1'b1;
            end
            // A misaligned target still retires the current instruction but freezes the PC
            if (commit) begin
                vld_q <= 1'b0;
                cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (next_misaligned) begin
                    halted_q <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

    assign o_imem_addr     = pc;
    assign o_pc_val        = pc;
    assign o_pc_plus4      = pc + 32'd4;
    assign o_cur_instr_val = instr_q;
    assign o_instr_vld     = vld_q;
    assign o_halted        = halted_q;
    assign o_retired_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a transaction-level model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst;
    pc_sel_e     sel;
    data_val_t   imm;
    data_val_t   alu;
    logic        exec_done;
    logic        ack;
    instr_t      rdata;
    logic        req;
    logic [31:0] addr;
    instr_t      cur;
    logic        vld;
    logic [31:0] pcv;
    logic [31:0] pc4;
    logic        halted;
    logic [3:0]  cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    fetch_unit #(.RESET_PC(32'h0), .CNT_WIDTH(4)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pc_sel        (sel),
        .i_imm_val       (imm),
        .i_alu_out       (alu),
        .i_exec_done     (exec_done),
        .o_imem_req      (req),
        .o_imem_addr     (addr),
        .i_imem_ack      (ack),
        .i_imem_rdata    (rdata),
        .o_cur_instr_val (cur),
        .o_instr_vld     (vld),
        .o_pc_val        (pcv),
        .o_pc_plus4      (pc4),
        .o_halted        (halted),
        .o_retired_cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the stage is either starting up, waiting for a word, holding a word, or halted
    logic        m_startup;
    logic        m_halted;
    logic        m_vld;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [3:0]  m_cnt;
    logic [31:0] m_tgt;
    logic        m_req;

    function automatic logic [31:0] target(input logic [31:0] p, input pc_sel_e s,
                                           input logic [31:0] i, input logic [31:0] a);
        if (s == PC_IMM_OFFSET) return p + i;
        if (s == PC_ALU_OUT)    return a & 32'hFFFF_FFFE;
        return p + 32'd4;
    endfunction

    assign m_tgt = target(m_pc, sel, imm, alu);
    assign m_req = !rst && !m_startup && !m_halted && !m_vld;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_startup <= 1'b1;
            m_halted  <= 1'b0;
            m_vld     <= 1'b0;
            m_pc      <= 32'h0;
            m_instr   <= 32'h0;
            m_cnt     <= 4'd0;
        end else if (m_startup) begin
            m_startup <= 1'b0;
        end else if (!m_halted) begin
            if (!m_vld) begin
                if (ack) begin
                    m_instr <= rdata;
                    m_vld   <= 1'b1;
                end
            end else if (exec_done) begin
                m_cnt <= m_cnt + 4'd1;
                m_vld <= 1'b0;
                if (m_tgt[1:0] != 2'b00) m_halted <= 1'b1;
                else                     m_pc     <= m_tgt;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_req",    {31'b0, req},    {31'b0, m_req});
        chk("m_addr",   addr,            m_pc);
        chk("m_pc",     pcv,             m_pc);
        chk("m_plus4",  pc4,             m_pc + 32'd4);
        chk("m_vld",    {31'b0, vld},    {31'b0, m_vld});
        chk("m_instr",  cur,             m_instr);
        chk("m_halted", {31'b0, halted}, {31'b0, m_halted});
        chk("m_cnt",    {28'b0, cnt},    {28'b0, m_cnt});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 50) begin
            step();
            n++;
        end
        chk("req_timeout", {31'b0, req}, 32'd1);
    endtask

    task automatic do_fetch(input int waits, input logic [31:0] data);
        wait_req();
        repeat (waits) step();
        ack   = 1'b1;
        rdata = data;
        step();
        ack   = 1'b0;
    endtask

    task automatic commit(input pc_sel_e s, input logic [31:0] i, input logic [31:0] a);
        int n = 0;
        while (!vld && n < 50) begin
            step();
            n++;
        end
        chk("vld_timeout", {31'b0, vld}, 32'd1);
        sel       = s;
        imm       = i;
        alu       = a;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        sel       = PC_INCR;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last;
        rst = 1'b1; sel = PC_INCR; imm = '0; alu = '0;
        exec_done = 1'b0; ack = 1'b0; rdata = '0;
        repeat (3) step();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_pc",  pcv,          32'h0);
        chk("rst_cnt", {28'b0, cnt}, 32'd0);
        chk("rst_vld", {31'b0, vld}, 32'd0);
        rst = 1'b0;
        chk("idle_no_req", {31'b0, req}, 32'd0);
        step();
        chk("fetch_req",  {31'b0, req}, 32'd1);
        chk("fetch_addr", addr,         32'h0);
        do_fetch(2, 32'h0050_0093);
        chk("first_vld",   {31'b0, vld}, 32'd1);
        chk("first_instr", cur,          32'h0050_0093);
        commit(PC_INCR, 32'h0, 32'h0);
        chk("incr_addr", addr,         32'h4);
        chk("incr_cnt",  {28'b0, cnt}, 32'd1);

        do_fetch(0, 32'h0000_0013);
        commit(PC_INCR, 32'h0, 32'h0);
        do_fetch(1, 32'h0000_0013);
        commit(pc_sel_e'(2'b11), 32'h0, 32'h0);
        chk("other_sel_addr", addr, 32'hC);
        do_fetch(0, 32'h0000_0013);
        commit(PC_INCR, 32'h0, 32'h0);
        do_fetch(0, 32'h0000_0013);
        chk("pc_at_10", pcv, 32'h10);
        commit(PC_IMM_OFFSET, 32'hFFFF_FFF8, 32'h0);
        chk("imm_neg_addr", addr, 32'h8);
        do_fetch(0, 32'h0000_0013);
        commit(PC_INCR, 32'h0, 32'h0);
        do_fetch(0, 32'h0000_0013);
        commit(PC_INCR, 32'h0, 32'h0);
        do_fetch(0, 32'h0000_0013);
        commit(PC_IMM_OFFSET, 32'h20, 32'h0);
        chk("imm_pos_addr", addr, 32'h30);
        chk("cnt_8", {28'b0, cnt}, 32'd8);

        wait_req();
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        chk("fetch_ignores_done", {31'b0, req}, 32'd1);
        ack = 1'b1; rdata = 32'hABCD_0013; exec_done = 1'b1;
        step();
        ack = 1'b0; exec_done = 1'b0;
        chk("ack_done_vld", {31'b0, vld}, 32'd1);
        chk("ack_done_cnt", {28'b0, cnt}, 32'd8);
        chk("ack_done_pc",  pcv,          32'h30);
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        step();
        chk("spurious_ack_instr", cur,          32'hABCD_0013);
        chk("spurious_ack_req",   {31'b0, req}, 32'd0);

        commit(PC_ALU_OUT, 32'h0, 32'h0000_0101);
        chk("alu_addr", addr,         32'h100);
        chk("alu_cnt",  {28'b0, cnt}, 32'd9);
        do_fetch(0, 32'h0000_0013);
        commit(PC_ALU_OUT, 32'h0, 32'h0000_0102);
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_pc",   pcv,             32'h100);
        chk("halt_cnt",  {28'b0, cnt},    32'd10);
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1; exec_done = 1'b1;
            step();
            ack = 1'b0; exec_done = 1'b0;
            chk("halt_req", {31'b0, req}, 32'd0);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_req();
        step();
        chk("midwait_req", {31'b0, req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("req_drops_on_rst", {31'b0, req}, 32'd0);
        step();
        rst = 1'b0;
        chk("rerst_idle_req", {31'b0, req},    32'd0);
        chk("rerst_cnt",      {28'b0, cnt},    32'd0);
        chk("rerst_halted",   {31'b0, halted}, 32'd0);
        step();
        chk("refetch_req",  {31'b0, req}, 32'd1);
        chk("refetch_addr", addr,         32'h0);

        last = 0;
        for (int k = 0; k < 16; k++) begin
            do_fetch(0, 32'h0000_0013);
            if (k > 0) chk("cadence", cyc - last, 32'd2);
            last = cyc;
            commit(PC_INCR, 32'h0, 32'h0);
        end
        chk("wrap_cnt",  {28'b0, cnt}, 32'd0);
        chk("wrap_addr", addr,         32'h40);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
